// File: rtl/pool2d_stream_pkg.sv
// pool2d_stream_pkg
// Shared constants and elaboration-time helpers for the streaming pooling unit.
//   DW_DEFAULT : default pixel width
//   clog2      : ceil(log2(n)), used for counter and shift widths
//   cnt_w      : counter width, at least one bit
//   accw       : accumulator width for a DW-bit pixel and a KxK window.
//                It is wider than DW only when POOL_AVG_EN is defined.
package pool2d_stream_pkg;

    localparam int DW_DEFAULT = 16;

`ifdef POOL_AVG_EN
    localparam int AVG_BUILD = 1;
`else
    localparam int AVG_BUILD = 0;
`endif

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << r) < n) r = r + 1;
        end
        return r;
    endfunction

    function automatic int cnt_w(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

    // A sum of K*K values needs 2*log2(K) guard bits above the pixel width.
    function automatic int accw(input int dw, input int k);
        return dw + AVG_BUILD * 2 * clog2(k);
    endfunction

endpackage

// File: rtl/pool2d_stream_line_buf.sv
// pool_line_buf
// One partial result per window column (IMG_W/K entries).
// Synchronous write, asynchronous read, no reset, so it maps to distributed RAM.
// Ports:
//   i_clk   : clock
//   i_we    : write enable
//   i_waddr : write address (window column)
//   i_wdata : partial result to store
//   i_raddr : read address (window column)
//   o_rdata : stored partial result, combinational
module pool_line_buf #(
    parameter int DEPTH = 4,
    parameter int W     = 16,
    parameter int AW    = 2
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/pool2d_stream.sv
// pool2d_stream
// Streaming KxK (stride K) pooling over one raster-order feature-map channel.
// The default build computes the signed max. Defining POOL_AVG_EN adds the
// i_avg input, which selects average pooling (sum >>> 2*log2(K)).
// Ports:
//   i_clk   : clock, rising edge
//   i_rst   : asynchronous active-high reset
//   i_valid : input pixel qualifier
//   i_sof   : first pixel of a frame; it restarts all window counters
//   i_data  : signed input pixel
//   i_avg   : (POOL_AVG_EN only) 1 = average, 0 = max; change only between frames
//   o_valid : one-cycle pulse per pooled result
//   o_data  : signed pooled result
//   o_last  : final result of the frame
module pool2d_stream
    import pool2d_stream_pkg::*;
#(
    parameter int DW    = pool2d_stream_pkg::DW_DEFAULT,
    parameter int K     = 2,
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    input  logic                 i_sof,
    input  logic signed [DW-1:0] i_data,
`ifdef POOL_AVG_EN
    input  logic                 i_avg,
`endif
    output logic                 o_valid,
    output logic signed [DW-1:0] o_data,
    output logic                 o_last
);

    localparam int NWX = IMG_W / K;
    localparam int NWY = IMG_H / K;
    localparam int AW  = accw(DW, K);
    localparam int SH  = 2 * clog2(K);
    localparam int CSW = cnt_w(K);
    localparam int WXW = cnt_w(NWX);
    localparam int WYW = cnt_w(NWY);

    localparam logic [CSW-1:0] SUB_LAST = CSW'(K - 1);
    localparam logic [WXW-1:0] WX_LAST  = WXW'(NWX - 1);
    localparam logic [WYW-1:0] WY_LAST  = WYW'(NWY - 1);

`ifdef POOL_AVG_EN
    generate
        if ((1 << clog2(K)) != K) begin : g_k_pow2_chk
            $error("pool2d_stream: K must be a power of two for average pooling");
        end
    endgenerate
`endif

    logic avg_sel;
`ifdef POOL_AVG_EN
    assign avg_sel = i_avg;
`else
    assign avg_sel = 1'b0;
`endif

    // Reduction operator: addition in average mode, otherwise the signed max.
    // Max values are sign-extended into AW, so comparing at AW equals comparing at DW.
    function automatic logic signed [AW-1:0] pool_f(input logic signed [AW-1:0] a,
                                                    input logic signed [AW-1:0] b,
                                                    input logic avg);
        if (avg) return a + b;
        return (a > b) ? a : b;
    endfunction

    logic [CSW-1:0] csub_reg, csub_eff, csub_next;
    logic [CSW-1:0] rsub_reg, rsub_eff, rsub_next;
    logic [WXW-1:0] wx_reg, wx_eff, wx_next;
    logic [WYW-1:0] wy_reg, wy_eff, wy_next;
    logic signed [AW-1:0] run_reg;

    logic signed [AW-1:0] din, seg, buf_rd, comb, res_acc, buf_wdata;
    logic seg_end, row_last, buf_we;

    assign din = AW'(i_data);

    always_comb begin
        // i_sof forces this pixel to window origin and drops any partial windows.
        // The same forcing makes i_sof win over a window-completing pixel.
        csub_eff = i_sof ? '0 : csub_reg;
        rsub_eff = i_sof ? '0 : rsub_reg;
        wx_eff   = i_sof ? '0 : wx_reg;
        wy_eff   = i_sof ? '0 : wy_reg;

        seg_end  = (csub_eff == SUB_LAST);
        row_last = (rsub_eff == SUB_LAST);

        seg  = pool_f(run_reg, din, avg_sel);
        comb = pool_f(buf_rd, seg, avg_sel);

        buf_we    = i_valid && seg_end && !row_last;
        buf_wdata = (rsub_eff == '0) ? seg : comb;

        res_acc = avg_sel ? (comb >>> SH) : comb;

        csub_next = csub_eff + CSW'(1);
        rsub_next = rsub_eff;
        wx_next   = wx_eff;
        wy_next   = wy_eff;
        if (seg_end) begin
            csub_next = '0;
            wx_next   = wx_eff + WXW'(1);
            if (wx_eff == WX_LAST) begin
                wx_next   = '0;
                rsub_next = rsub_eff + CSW'(1);
                if (row_last) begin
                    rsub_next = '0;
                    wy_next   = (wy_eff == WY_LAST) ? '0 : wy_eff + WYW'(1);
                end
            end
        end
    end

    pool_line_buf #(
        .DEPTH(NWX),
        .W    (AW),
        .AW   (WXW)
    ) u_line_buf (
        .i_clk  (i_clk),
        .i_we   (buf_we),
        .i_waddr(wx_eff),
        .i_wdata(buf_wdata),
        .i_raddr(wx_eff),
        .o_rdata(buf_rd)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            csub_reg <= '0;
            rsub_reg <= '0;
            wx_reg   <= '0;
            wy_reg   <= '0;
            run_reg  <= '0;
            o_valid  <= 1'b0;
            o_data   <= '0;
            o_last   <= 1'b0;
        end else if (i_valid) begin
            csub_reg <= csub_next;
            rsub_reg <= rsub_next;
            wx_reg   <= wx_next;
            wy_reg   <= wy_next;
            run_reg  <= (csub_eff == '0) ? din : seg;
            o_valid  <= seg_end && row_last;
            o_last   <= seg_end && row_last && (wx_eff == WX_LAST) && (wy_eff == WY_LAST);
            if (seg_end && row_last) o_data <= DW'(res_acc);
        end else begin
            o_valid <= 1'b0;
            o_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pool2d_stream.sv
// tb_pool2d_stream
// Directed bench for pool2d_stream with DW=8, K=2, IMG_W=4, IMG_H=2 in the
// default (max) build. Every expected value below was computed by hand.
module tb_pool2d_stream;

    localparam int DW = 8;

    typedef logic signed [DW-1:0] frame_t [8];
    typedef int gap_t [8];

    logic                 clk;
    logic                 rst;
    logic                 valid;
    logic                 sof;
    logic signed [DW-1:0] data;
    logic                 o_valid;
    logic signed [DW-1:0] o_data;
    logic                 o_last;

    int passed;
    int total;

    pool2d_stream #(
        .DW   (DW),
        .K    (2),
        .IMG_W(4),
        .IMG_H(2)
    ) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_valid(valid),
        .i_sof  (sof),
        .i_data (data),
        .o_valid(o_valid),
        .o_data (o_data),
        .o_last (o_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        assert (act === exp) passed++;
        else $error("FAIL %s: got %0d expected %0d", tag, $signed(act), $signed(exp));
    endtask

    // Called just after a rising edge. Presents one pixel, lets it be accepted,
    // then checks the registered outputs one edge later. Idle gap cycles follow,
    // and o_valid must stay low during them.
    task automatic push(input string tag, input logic signed [DW-1:0] d, input logic s,
                        input logic ev, input logic signed [DW-1:0] ed, input logic el,
                        input int gap);
        valid = 1'b1;
        sof   = s;
        data  = d;
        @(posedge clk);
        #1;
        valid = 1'b0;
        sof   = 1'b0;
        $display("px %s d=%0d sof=%0b -> o_valid=%0b o_data=%0d o_last=%0b",
                 tag, d, s, o_valid, o_data, o_last);
        chk({tag, ".valid"}, {7'd0, o_valid}, {7'd0, ev});
        chk({tag, ".last"}, {7'd0, o_last}, {7'd0, el});
        if (ev) chk({tag, ".data"}, o_data, ed);
        for (int g = 0; g < gap; g++) begin
            @(posedge clk);
            #1;
            chk($sformatf("%s.gap%0d", tag, g), {7'd0, o_valid}, 8'd0);
        end
    endtask

    // One full 4x2 frame: the results appear after pixel 6 (window 0) and
    // after pixel 8 (window 1, last).
    task automatic run_frame(input string tag, input frame_t px, input logic sof_first,
                             input gap_t gaps, input logic signed [DW-1:0] e0,
                             input logic signed [DW-1:0] e1);
        for (int i = 0; i < 8; i++) begin
            push($sformatf("%s.p%0d", tag, i + 1), px[i], (i == 0) ? sof_first : 1'b0,
                 (i == 5 || i == 7), (i == 5) ? e0 : e1, (i == 7), gaps[i]);
        end
    endtask

    frame_t golden;
    frame_t negs;
    gap_t   no_gaps;
    gap_t   some_gaps;

    initial begin
        passed = 0;
        total  = 0;
        golden    = '{8'sd1, 8'sd5, -8'sd3, -8'sd7, 8'sd2, 8'sd0, -8'sd1, -8'sd128};
        negs      = '{default: -8'sd128};
        no_gaps   = '{default: 0};
        some_gaps = '{0, 1, 2, 3, 1, 0, 3, 2};

        rst   = 1'b1;
        valid = 1'b0;
        sof   = 1'b0;
        data  = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset.valid", {7'd0, o_valid}, 8'd0);
        chk("reset.data", o_data, 8'd0);
        chk("reset.last", {7'd0, o_last}, 8'd0);
        rst = 1'b0;

        // Golden frame, back to back
        run_frame("f1", golden, 1'b1, no_gaps, 8'sd5, -8'sd1);

        // Same stream with idle gaps of 0..3 cycles
        run_frame("gap", golden, 1'b1, some_gaps, 8'sd5, -8'sd1);

        // All -128: there is no clamp at zero
        run_frame("neg", negs, 1'b1, no_gaps, -8'sd128, -8'sd128);

        // i_sof again at pixel 3: the aborted window produces nothing
        push("ab.p1", 8'sd10, 1'b1, 1'b0, 8'sd0, 1'b0, 0);
        push("ab.p2", 8'sd20, 1'b0, 1'b0, 8'sd0, 1'b0, 0);
        run_frame("ab", golden, 1'b1, no_gaps, 8'sd5, -8'sd1);

        // i_sof on a window-completing pixel: the restart takes priority
        for (int i = 0; i < 7; i++)
            push($sformatf("co.p%0d", i + 1), golden[i], (i == 0), (i == 5), 8'sd5, 1'b0, 0);
        push("co.n1", 8'sd100, 1'b1, 1'b0, 8'sd0, 1'b0, 0);
        for (int i = 1; i < 8; i++)
            push($sformatf("co.n%0d", i + 1), golden[i], 1'b0, (i == 5 || i == 7),
                 (i == 5) ? 8'sd100 : -8'sd1, (i == 7), 0);

        // Asynchronous reset mid-frame, applied while o_valid is high
        for (int i = 0; i < 6; i++)
            push($sformatf("rs.p%0d", i + 1), golden[i], (i == 0), (i == 5), 8'sd5, 1'b0, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst.valid", {7'd0, o_valid}, 8'd0);
        chk("arst.data", o_data, 8'd0);
        chk("arst.last", {7'd0, o_last}, 8'd0);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("arst.idle", {7'd0, o_valid}, 8'd0);
        // No i_sof: the counters have to be back at the origin
        run_frame("post", golden, 1'b0, no_gaps, 8'sd5, -8'sd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish (got running, expected finished)");
        $fatal(1, "timeout");
    end

endmodule
